stat_scheduler: RTL and testbench

STAT_SCHEDULER -- requirements
Module: stat_scheduler

---
 rtl/stat_scheduler_pkg.sv | 64 ++++++
 rtl/stat_scheduler_tick_timer.sv | 31 +++
 rtl/stat_scheduler.sv | 149 ++++++++++++++
 tb/tb_stat_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_scheduler_pkg.sv
// Shared definitions for the pet stat scheduler: stat indices, UART command
// bytes, FSM state encoding and the small decode helpers used by the top.
package stat_scheduler_pkg;

  localparam logic [2:0] STAT_HUNGER    = 3'd0;
  localparam logic [2:0] STAT_HAPPINESS = 3'd1;
  localparam logic [2:0] STAT_HEALTH    = 3'd2;
  localparam logic [2:0] STAT_HYGIENE   = 3'd3;
  localparam logic [2:0] STAT_ENERGY    = 3'd4;
  localparam logic [2:0] STAT_SOCIAL    = 3'd5;

  localparam logic [7:0] CMD_HUNGER    = 8'h65;
  localparam logic [7:0] CMD_HAPPINESS = 8'h73;
  localparam logic [7:0] CMD_HEALTH    = 8'h6D;
  localparam logic [7:0] CMD_HYGIENE   = 8'h63;
  localparam logic [7:0] CMD_ENERGY    = 8'h7A;
  localparam logic [7:0] CMD_SOCIAL    = 8'h70;
  localparam logic [7:0] CMD_ARM       = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE_TICK = 2'd1,
    ST_ISSUE_CMD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] stat;
  } stat_sel_t;

  // Two LFSR codes map to no stat so that some ticks leave the pet alone.
  function automatic stat_sel_t decode_random(input logic [2:0] r);
    stat_sel_t sel;
    sel.hit  = 1'b1;
    sel.stat = STAT_HAPPINESS;
    case (r)
      3'b000:  sel.stat = STAT_HAPPINESS;
      3'b001:  sel.stat = STAT_HUNGER;
      3'b010:  sel.stat = STAT_HEALTH;
      3'b011:  sel.stat = STAT_HYGIENE;
      3'b110:  sel.stat = STAT_ENERGY;
      3'b101:  sel.stat = STAT_SOCIAL;
      default: sel.hit  = 1'b0;
    endcase
    return sel;
  endfunction

  function automatic stat_sel_t decode_cmd(input logic [7:0] b);
    stat_sel_t sel;
    sel.hit  = 1'b1;
    sel.stat = STAT_HUNGER;
    case (b)
      CMD_HUNGER:    sel.stat = STAT_HUNGER;
      CMD_HAPPINESS: sel.stat = STAT_HAPPINESS;
      CMD_HEALTH:    sel.stat = STAT_HEALTH;
      CMD_HYGIENE:   sel.stat = STAT_HYGIENE;
      CMD_ENERGY:    sel.stat = STAT_ENERGY;
      CMD_SOCIAL:    sel.stat = STAT_SOCIAL;
      default:       sel.hit  = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/stat_scheduler_tick_timer.sv
// Free-running decay tick timer: one-cycle wrap strobe every TICK_CYCLES
// clocks and a 'second' phase bit that flips on every wrap.
module stat_scheduler_tick_timer #(
  parameter int TICK_CYCLES = 27000000,
  parameter int CNT_W       = 28
) (
  input  logic clk,
  input  logic reset_n,
  output logic wrap,
  output logic second
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign wrap = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      second <= 1'b0;
    end else if (wrap) begin
      count  <= '0;
      second <= ~second;
    end else begin
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stat_scheduler.sv
// Arbitrates periodic decay ticks and user care commands into a single
// registered stat-update op stream; ticks always win over commands.
module stat_scheduler #(
  parameter int TICK_CYCLES = 27000000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic [7:0] random,
  output logic       op_valid,
  output logic [2:0] op_stat,
  output logic       op_inc,
  input  logic       op_ready,
  output logic       second,
  output logic       tick_overrun
);

  import stat_scheduler_pkg::*;

  state_t     state;
  state_t     state_next;
  logic       wrap;
  logic       tick_pending;
  logic [2:0] tick_stat;
  logic       buf_full;
  logic [2:0] buf_stat;
  logic       armed;
  logic       op_valid_next;
  logic [2:0] op_stat_next;
  logic       op_inc_next;
  stat_sel_t  tick_sel;
  stat_sel_t  cmd_sel;
  logic       cmd_accept;
  logic       tick_done;
  logic       cmd_done;
  logic       unused_random;

  stat_scheduler_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .CNT_W      (CNT_W)
  ) u_tick_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .wrap   (wrap),
    .second (second)
  );

  assign tick_sel      = decode_random(random[2:0]);
  assign cmd_sel       = decode_cmd(cmd_byte);
  assign unused_random = ^random[7:3];

  assign cmd_ready  = reset_n && !buf_full && (state != ST_ISSUE_CMD);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign tick_done  = (state == ST_ISSUE_TICK) && op_ready;
  assign cmd_done   = (state == ST_ISSUE_CMD) && op_ready;

  // A wrap landing on the edge that retires the tick op re-arms the tick
  // instead of counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_pending <= 1'b0;
      tick_stat    <= '0;
      tick_overrun <= 1'b0;
    end else begin
      if (tick_done) begin
        tick_pending <= 1'b0;
      end
      if (wrap && tick_sel.hit) begin
        tick_pending <= 1'b1;
        tick_stat    <= tick_sel.stat;
        if (tick_pending && !tick_done) begin
          tick_overrun <= 1'b1;
        end
      end
    end
  end

  // One care command is accepted per 0x00 arming byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_stat <= '0;
      armed    <= 1'b1;
    end else begin
      if (cmd_done) begin
        buf_full <= 1'b0;
      end
      if (cmd_accept) begin
        if (cmd_byte == CMD_ARM) begin
          armed <= 1'b1;
        end else if (cmd_sel.hit && armed) begin
          buf_full <= 1'b1;
          buf_stat <= cmd_sel.stat;
          armed    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_valid <= 1'b0;
      op_stat  <= '0;
      op_inc   <= 1'b0;
    end else begin
      state    <= state_next;
      op_valid <= op_valid_next;
      op_stat  <= op_stat_next;
      op_inc   <= op_inc_next;
    end
  end

  always_comb begin
    state_next    = state;
    op_valid_next = op_valid;
    op_stat_next  = op_stat;
    op_inc_next   = op_inc;
    case (state)
      ST_IDLE: begin
        if (tick_pending) begin
          state_next    = ST_ISSUE_TICK;
          op_valid_next = 1'b1;
          op_stat_next  = tick_stat;
          op_inc_next   = 1'b1;
        end else if (buf_full) begin
          state_next    = ST_ISSUE_CMD;
          op_valid_next = 1'b1;
          op_stat_next  = buf_stat;
          op_inc_next   = 1'b0;
        end
      end
      ST_ISSUE_TICK, ST_ISSUE_CMD: begin
        if (op_ready) begin
          state_next    = ST_IDLE;
          op_valid_next = 1'b0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        op_valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stat_scheduler.sv
// Self-checking bench for stat_scheduler: directed corner sequences, a table of
// command vectors, and a randomized run against a cycle-level reference model.
module tb_stat_scheduler;

  localparam int TICK = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_ready;
  logic [7:0] random = 8'h00;
  logic       op_valid;
  logic [2:0] op_stat;
  logic       op_inc;
  logic       op_ready = 1'b0;
  logic       second;
  logic       tick_overrun;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int stat;
    int inc;
  } op_rec_t;

  typedef struct {
    logic [7:0] cmd;
    bit         arm_first;
    int         exp_stat;
  } cmd_vec_t;

  op_rec_t  fire_q[$];
  cmd_vec_t vecs[11];

  stat_scheduler #(
    .TICK_CYCLES(TICK),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_ready   (cmd_ready),
    .random      (random),
    .op_valid    (op_valid),
    .op_stat     (op_stat),
    .op_inc      (op_inc),
    .op_ready    (op_ready),
    .second      (second),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: stat codes as ints (-1 = none), op phase 0 none / 1 tick / 2 cmd.
  int rnd_map [8] = '{1, 0, 2, 3, -1, 5, 4, -1};
  int m_cyc, m_pstat, m_bstat, m_op, m_opstat;
  bit m_second, m_pend, m_overrun, m_buf, m_armed, m_opinc;

  function automatic int cmd_map(input logic [7:0] b);
    case (b)
      8'h65:   return 0;
      8'h73:   return 1;
      8'h6D:   return 2;
      8'h63:   return 3;
      8'h7A:   return 4;
      8'h70:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic bit model_cmd_ready();
    return reset_n && !m_buf && (m_op != 2);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_second = 0; m_pend = 0; m_pstat = 0; m_overrun = 0;
    m_buf = 0; m_bstat = 0; m_armed = 1; m_op = 0; m_opstat = 0; m_opinc = 0;
  endtask

  task automatic model_step();
    bit wrap, fire, accept, pend;
    int tstat, cstat, nxt;
    wrap   = (m_cyc % TICK) == (TICK - 1);
    fire   = (m_op != 0) && op_ready;
    tstat  = rnd_map[random[2:0]];
    cstat  = cmd_map(cmd_byte);
    accept = cmd_valid && model_cmd_ready();
    nxt    = m_op;
    if (m_op == 0) begin
      if (m_pend) begin
        nxt = 1; m_opstat = m_pstat; m_opinc = 1;
      end else if (m_buf) begin
        nxt = 2; m_opstat = m_bstat; m_opinc = 0;
      end
    end else if (fire) begin
      nxt = 0;
    end
    pend = m_pend && !(fire && m_op == 1);
    if (wrap && tstat >= 0) begin
      if (pend) m_overrun = 1;
      pend    = 1;
      m_pstat = tstat;
    end
    if (fire && m_op == 2) m_buf = 0;
    if (accept) begin
      if (cmd_byte == 8'h00) begin
        m_armed = 1;
      end else if (cstat >= 0 && m_armed) begin
        m_buf = 1; m_bstat = cstat; m_armed = 0;
      end
    end
    m_pend   = pend;
    m_op     = nxt;
    m_second = m_second ^ wrap;
    m_cyc++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    #1;
    check_output("model_op_valid", int'(op_valid), int'(m_op != 0));
    check_output("model_op_stat", int'(op_stat), m_opstat);
    check_output("model_op_inc", int'(op_inc), int'(m_opinc));
    check_output("model_second", int'(second), int'(m_second));
    check_output("model_tick_overrun", int'(tick_overrun), int'(m_overrun));
    check_output("model_cmd_ready", int'(cmd_ready), int'(model_cmd_ready()));
  end

  // Records every op that will be taken on the upcoming rising edge.
  always @(negedge clk) begin
    #1;
    if (reset_n && op_valid && op_ready) fire_q.push_back('{int'(op_stat), int'(op_inc)});
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fire_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (cmd_ready) done = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) check_output("send_byte_timeout", 0, 1);
  endtask

  task automatic apply_stimulus(input cmd_vec_t v);
    fire_q.delete();
    if (v.arm_first) send_byte(8'h00);
    send_byte(v.cmd);
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int  cyc;
    bit  seen;
    logic [7:0] byte_pool [10];

    vecs[0]  = '{8'h65, 1'b1, 0};
    vecs[1]  = '{8'h73, 1'b1, 1};
    vecs[2]  = '{8'h6D, 1'b1, 2};
    vecs[3]  = '{8'h63, 1'b1, 3};
    vecs[4]  = '{8'h7A, 1'b1, 4};
    vecs[5]  = '{8'h70, 1'b1, 5};
    vecs[6]  = '{8'h70, 1'b0, -1};
    vecs[7]  = '{8'h78, 1'b1, -1};
    vecs[8]  = '{8'h45, 1'b0, -1};
    vecs[9]  = '{8'h65, 1'b0, 0};
    vecs[10] = '{8'h65, 1'b0, -1};
    byte_pool = '{8'h65, 8'h73, 8'h6D, 8'h63, 8'h7A, 8'h70, 8'h00, 8'h00, 8'h78, 8'h41};

    // Reset values, and cmd_ready rising as soon as reset is released.
    @(negedge clk); #1;
    check_output("reset_op_valid", int'(op_valid), 0);
    check_output("reset_op_stat", int'(op_stat), 0);
    check_output("reset_op_inc", int'(op_inc), 0);
    check_output("reset_second", int'(second), 0);
    check_output("reset_overrun", int'(tick_overrun), 0);
    check_output("reset_cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_output("release_cmd_ready", int'(cmd_ready), 1);

    // Health tick: op one cycle after wrap, second period of TICK cycles.
    random = 8'h02; op_ready = 1'b1;
    do_reset();
    seen = 0; cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      cyc = i + 1;
      if (second) seen = 1;
    end
    check_output("first_wrap_cycle", cyc, 8);
    check_output("op_valid_at_wrap", int'(op_valid), 0);
    @(negedge clk); #1;
    check_output("tick_op_valid", int'(op_valid), 1);
    check_output("tick_op_stat", int'(op_stat), 2);
    check_output("tick_op_inc", int'(op_inc), 1);
    seen = 0; cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      cyc = i + 2;
      if (!second) seen = 1;
    end
    check_output("second_period", cyc, 8);

    // e, e, 0x00, e: the second 'e' arrives disarmed.
    random = 8'h07; op_ready = 1'b1;
    do_reset();
    send_byte(8'h65); send_byte(8'h65); send_byte(8'h00); send_byte(8'h65);
    repeat (6) @(negedge clk); #1;
    check_output("eee_op_count", fire_q.size(), 2);
    foreach (fire_q[i]) begin
      check_output("eee_op_stat", fire_q[i].stat, 0);
      check_output("eee_op_inc", fire_q[i].inc, 0);
    end

    // Wrap and 's' accept on the same edge: tick op first.
    random = 8'h03; op_ready = 1'b1;
    do_reset();
    repeat (7) @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = 8'h73;
    #1;
    check_output("cmd_ready_at_wrap", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0; random = 8'h07;
    repeat (8) @(negedge clk); #1;
    check_output("coincide_op_count", fire_q.size(), 2);
    if (fire_q.size() >= 2) begin
      check_output("coincide_first_stat", fire_q[0].stat, 3);
      check_output("coincide_first_inc", fire_q[0].inc, 1);
      check_output("coincide_second_stat", fire_q[1].stat, 1);
      check_output("coincide_second_inc", fire_q[1].inc, 0);
    end

    // Backpressure across two wraps: op held stable, overrun raised, one op on release.
    random = 8'h02; op_ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    random = 8'h06;
    for (int i = 9; i <= 20; i++) begin
      @(negedge clk); #1;
      check_output("stall_op_valid", int'(op_valid), 1);
      check_output("stall_op_stat", int'(op_stat), 2);
      check_output("stall_op_inc", int'(op_inc), 1);
      if (i == 15) check_output("overrun_before", int'(tick_overrun), 0);
      if (i == 16) check_output("overrun_after", int'(tick_overrun), 1);
    end
    @(negedge clk);
    op_ready = 1'b1; random = 8'h07;
    repeat (10) @(negedge clk); #1;
    check_output("stall_op_count", fire_q.size(), 1);
    if (fire_q.size() == 1) begin
      check_output("stall_fired_stat", fire_q[0].stat, 2);
      check_output("stall_fired_inc", fire_q[0].inc, 1);
    end
    check_output("overrun_sticky", int'(tick_overrun), 1);

    // No-op random code and unmapped byte.
    random = 8'h07; op_ready = 1'b1;
    do_reset();
    repeat (8) @(negedge clk); #1;
    check_output("noop_second", int'(second), 1);
    send_byte(8'h78);
    repeat (6) @(negedge clk); #1;
    check_output("noop_op_count", fire_q.size(), 0);

    // Reset while a command op is stalled.
    random = 8'h07; op_ready = 1'b0;
    do_reset();
    send_byte(8'h63);
    repeat (3) @(negedge clk); #1;
    check_output("held_cmd_valid", int'(op_valid), 1);
    check_output("held_cmd_stat", int'(op_stat), 3);
    check_output("held_cmd_inc", int'(op_inc), 0);
    check_output("held_cmd_ready", int'(cmd_ready), 0);
    #1 reset_n = 1'b0;
    #1;
    check_output("midreset_op_valid", int'(op_valid), 0);
    check_output("midreset_cmd_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; op_ready = 1'b1;
    fire_q.delete();
    repeat (6) @(negedge clk); #1;
    check_output("post_reset_op_count", fire_q.size(), 0);
    send_byte(8'h63);
    repeat (6) @(negedge clk); #1;
    check_output("rearmed_op_count", fire_q.size(), 1);
    if (fire_q.size() == 1) begin
      check_output("rearmed_op_stat", fire_q[0].stat, 3);
      check_output("rearmed_op_inc", fire_q[0].inc, 0);
    end

    // Command table, ticks suppressed.
    random = 8'h07; op_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("table%0d_op_count", i), fire_q.size(), (vecs[i].exp_stat >= 0) ? 1 : 0);
      if (vecs[i].exp_stat >= 0 && fire_q.size() == 1) begin
        check_output($sformatf("table%0d_op_stat", i), fire_q[0].stat, vecs[i].exp_stat);
        check_output($sformatf("table%0d_op_inc", i), fire_q[0].inc, 0);
      end
    end

    // Randomized traffic against the model, with one reset pulse mid-run.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      random    = 8'($urandom);
      op_ready  = ($urandom_range(0, 3) != 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_byte  = byte_pool[$urandom_range(0, 9)];
      if (i == 400) reset_n = 1'b0;
      if (i == 402) reset_n = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
